// File: rtl/uart_transmitter.sv
`timescale 1ns / 1ps
// UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined) fed by a small circular FIFO.
// tx is registered from the FSM state, so the line trails the state by one cycle.
module uart_transmitter #(
  parameter int unsigned clock_frequency     = 50000000,
  parameter int unsigned baud_rate           = 9600,
  parameter int unsigned clock_cycles_in_bit = clock_frequency / baud_rate,
  parameter int unsigned fifo_depth          = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CntW = (clock_cycles_in_bit > 1) ? $clog2(clock_cycles_in_bit) : 1;
  localparam int unsigned PtrW = $clog2(fifo_depth);
  localparam logic [CntW-1:0] CycLast  = CntW'(clock_cycles_in_bit - 1);
  localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(fifo_depth);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [7:0]      mem_q [fifo_depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            push, pop;

  state_e          state_q, state_d;
  logic [CntW-1:0] cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            bit_done, fifo_empty;

  assign byte_ready = (count_q != FifoFull);
  assign fifo_empty = (count_q == '0);
  assign push       = byte_valid & byte_ready;
  assign bit_done   = (cyc_q == CycLast);
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) | !fifo_empty;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= byte_data;
    end
  end

  // Pointers wrap naturally because fifo_depth is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          cyc_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_done) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      StData: begin
        tx_d = data_q[bit_q];
        if (bit_done) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        tx_d = ^data_q;
        if (bit_done) begin
          cyc_d   = '0;
          state_d = StStop;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        tx_d = 1'b1;
        if (bit_done) begin
          cyc_d = '0;
          // Back-to-back frames: the next start bit follows the stop bit with no idle cycle.
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

endmodule
